// File: rtl/snx_pkg.sv
// Shared types and constants for the SNX memory responder.
package snx_pkg;

    localparam int WORD_W = 16;  // CPU word width
    localparam int IO_BIT = 15;  // data address bit selecting the I/O space
    localparam int IO_W   = 8;   // switch and LED width

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // True when a data address targets the I/O space rather than dmem.
    function automatic logic is_io(input logic [WORD_W-1:0] a);
        return a[IO_BIT];
    endfunction

endpackage

// File: rtl/snx_ram.sv
// 2^AW x 16 single-clock RAM: one write port, one registered read port.
// A read and a write to the same word in one cycle return the old data.
module snx_ram
    import snx_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**AW];

    // Array write; contents are deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; holds its value between reads, output clears on reset.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/snx_mem_responder.sv
// Memory/I-O responder for a small 16-bit CPU: program-load port,
// independent instruction and data memories, switch input, LED output,
// and a run/halt sequencer with a run-cycle counter.
module snx_mem_responder
    import snx_pkg::*;
#(
    parameter int AW = 10,
    parameter int CW = 32
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic [WORD_W-1:0] iadrs,
    input  logic              inst_read,
    output logic [WORD_W-1:0] inst,
    input  logic [WORD_W-1:0] adrs,
    input  logic              memory_read,
    input  logic              memory_write,
    input  logic [WORD_W-1:0] datao,
    output logic [WORD_W-1:0] datai,
    input  logic              hlt,
    input  logic [IO_W-1:0]   sw,
    output logic [IO_W-1:0]   led,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [AW-1:0]     ld_adrs,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_done,
    output logic              cpu_reset,
    output logic              halted,
    output logic [CW-1:0]     cycles
);

    state_t state, state_nx;

    logic              load_wr, run_wr, data_io;
    logic              imem_we, dmem_we, dmem_re, led_we;
    logic [AW-1:0]     dmem_waddr;
    logic [WORD_W-1:0] dmem_wdata, dmem_q;
    logic [IO_W-1:0]   sw_meta, sw_sync;
    logic [WORD_W-1:0] io_q;
    logic              sel_io;

    // Address bits above the memory size alias onto the same words.
    logic unused;
    assign unused = ^{iadrs[WORD_W-1:AW], adrs[IO_BIT-1:AW]};

    // State register.
    always_ff @(posedge m_clock) begin
        if (p_reset) state <= ST_LOAD;
        else         state <= state_nx;
    end

    // Next-state and status outputs; HALTED is left only through reset.
    always_comb begin
        state_nx  = state;
        ld_ready  = 1'b0;
        cpu_reset = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_LOAD: begin
                ld_ready  = 1'b1;
                cpu_reset = 1'b1;
                if (ld_done) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (hlt) state_nx = ST_HALTED;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    // Write decode: loader owns the memories in LOAD, the CPU owns dmem in
    // RUN (including the hlt cycle), nothing writes once halted.
    assign data_io    = is_io(adrs);
    assign load_wr    = (state == ST_LOAD) && ld_valid;
    assign run_wr     = (state == ST_RUN) && memory_write;
    assign imem_we    = load_wr && !ld_sel;
    assign dmem_we    = (load_wr && ld_sel) || (run_wr && !data_io);
    assign dmem_waddr = load_wr ? ld_adrs : adrs[AW-1:0];
    assign dmem_wdata = load_wr ? ld_data : datao;
    assign led_we     = run_wr && data_io;
    assign dmem_re    = memory_read && !data_io;

    snx_ram #(.AW(AW)) u_imem (
        .clk   (m_clock),
        .rst   (p_reset),
        .we    (imem_we),
        .waddr (ld_adrs),
        .wdata (ld_data),
        .re    (inst_read),
        .raddr (iadrs[AW-1:0]),
        .rdata (inst)
    );

    snx_ram #(.AW(AW)) u_dmem (
        .clk   (m_clock),
        .rst   (p_reset),
        .we    (dmem_we),
        .waddr (dmem_waddr),
        .wdata (dmem_wdata),
        .re    (dmem_re),
        .raddr (adrs[AW-1:0]),
        .rdata (dmem_q)
    );

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // I/O read capture and source select for datai; sel_io remembers which
    // space the most recent data read targeted so datai holds between reads.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            io_q   <= '0;
            sel_io <= 1'b0;
        end else if (memory_read) begin
            sel_io <= data_io;
            if (data_io) io_q <= {{(WORD_W-IO_W){1'b0}}, sw_sync};
        end
    end

    assign datai = sel_io ? io_q : dmem_q;

    // LED register, written only by the CPU while running.
    always_ff @(posedge m_clock) begin
        if (p_reset)     led <= '0;
        else if (led_we) led <= datao[IO_W-1:0];
    end

    // Run-cycle counter: counts every RUN cycle, wraps naturally.
    always_ff @(posedge m_clock) begin
        if (p_reset)              cycles <= '0;
        else if (state == ST_RUN) cycles <= cycles + CW'(1);
    end

endmodule
